// File: rtl/encoder_n_serial_pkg.sv
// Shared types and helpers for the serial N-bit request encoder.
// The one-hot test takes a fixed-width vector so any N up to MAX_N can use it.
package enc_pkg;

    localparam int MAX_N = 64;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // True when exactly one bit of vec is set.
    function automatic logic onehot_cnt_is1(input logic [MAX_N-1:0] vec);
        logic [MAX_N-1:0] low_clr;
        low_clr = vec & (vec - {{(MAX_N-1){1'b0}}, 1'b1});
        return (vec != {MAX_N{1'b0}}) && (low_clr == {MAX_N{1'b0}});
    endfunction

endpackage

// File: rtl/encoder_n_serial_prio.sv
// Combinational priority encoder: index of the first set bit of vec,
// scanning upward from bit 0 when LSB_FIRST=1, downward from bit N-1 otherwise.
module prio_enc_n #(
    parameter int N         = 8,
    parameter bit LSB_FIRST = 1'b1,
    localparam int W        = $clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         found
);

    // Later loop iterations overwrite earlier ones, so scan from lowest to highest priority.
    always_comb begin
        idx   = {W{1'b0}};
        found = |vec;
        if (LSB_FIRST) begin
            for (int i = N - 1; i >= 0; i--) begin
                idx = vec[i] ? W'(i) : idx;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                idx = vec[i] ? W'(i) : idx;
            end
        end
    end

endmodule

// File: rtl/encoder_n_serial.sv
// Serial encoder: accepts a multi-hot vector and streams the index of every
// set bit in priority order, one per output handshake, with a single beat for all-zero.
module encoder_n_serial
    import enc_pkg::*;
#(
    parameter int N         = 8,
    parameter bit LSB_FIRST = 1'b1,
    localparam int W        = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_vec,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_none,
    output logic         out_last
);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [N-1:0]     pending_r;
    logic             none_r;
    logic [W-1:0]     idx_s;
    logic             found_s;
    logic [N-1:0]     clr_mask_s;
    logic [MAX_N-1:0] pend_ext_s;
    logic             acc_s;
    logic             beat_s;

    prio_enc_n #(
        .N         (N),
        .LSB_FIRST (LSB_FIRST)
    ) u_prio (
        .vec   (pending_r),
        .idx   (idx_s),
        .found (found_s)
    );

    assign acc_s  = in_valid & in_ready;
    assign beat_s = out_valid & out_ready;

    // Bit to drop from pending once the current beat is consumed.
    always_comb begin
        clr_mask_s = {{(N-1){1'b0}}, found_s} << idx_s;
    end

    // Zero-extend pending to the helper's fixed width.
    always_comb begin
        pend_ext_s          = {MAX_N{1'b0}};
        pend_ext_s[N-1:0]   = pending_r;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Pending vector and all-zero flag, loaded on input handshake and drained per beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_r <= {N{1'b0}};
            none_r    <= 1'b0;
        end else if (acc_s) begin
            pending_r <= in_vec;
            none_r    <= (in_vec == {N{1'b0}});
        end else if (beat_s) begin
            pending_r <= pending_r & ~clr_mask_s;
            none_r    <= none_r;
        end else begin
            pending_r <= pending_r;
            none_r    <= none_r;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_nxt_s = EMIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            EMIT: begin
                if (out_ready && out_last) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = EMIT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Outputs: decoded from state and pending, so they hold while stalled.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_idx   = {W{1'b0}};
        out_none  = 1'b0;
        out_last  = 1'b0;
        case (state_r)
            IDLE: begin
                in_ready = 1'b1;
            end
            EMIT: begin
                out_valid = 1'b1;
                out_idx   = idx_s;
                out_none  = none_r;
                out_last  = none_r | onehot_cnt_is1(pend_ext_s);
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_encoder_n_serial.sv
// Scoreboard bench for encoder_n_serial: three instances (N=8 LSB-first,
// N=8 MSB-first, N=4 MSB-first), randomized and directed vectors, decoupled monitor.
module tb_encoder_n_serial;

    logic       clk;
    logic [2:0] rst_v;
    logic [2:0] in_valid_v;
    logic [2:0] out_ready_v;
    logic [7:0] vec_in [3];
    logic [2:0] in_ready_o, out_valid_o, none_o, last_o;
    logic [2:0] idx_a, idx_b;
    logic [1:0] idx_c;
    logic [2:0] idx_o [3];

    logic [4:0] q0[$];
    logic [4:0] q1[$];
    logic [4:0] q2[$];

    int         mode [3];
    logic       stall_prev [3];
    logic [4:0] stall_val [3];
    logic       idle_exp [3];
    int         n_vec = 0;
    int         n_err = 0;

    assign idx_o[0] = idx_a;
    assign idx_o[1] = idx_b;
    assign idx_o[2] = {1'b0, idx_c};

    encoder_n_serial #(.N(8), .LSB_FIRST(1'b1)) u_a (
        .clk(clk), .rst(rst_v[0]), .in_valid(in_valid_v[0]), .in_ready(in_ready_o[0]),
        .in_vec(vec_in[0]), .out_valid(out_valid_o[0]), .out_ready(out_ready_v[0]),
        .out_idx(idx_a), .out_none(none_o[0]), .out_last(last_o[0]));

    encoder_n_serial #(.N(8), .LSB_FIRST(1'b0)) u_b (
        .clk(clk), .rst(rst_v[1]), .in_valid(in_valid_v[1]), .in_ready(in_ready_o[1]),
        .in_vec(vec_in[1]), .out_valid(out_valid_o[1]), .out_ready(out_ready_v[1]),
        .out_idx(idx_b), .out_none(none_o[1]), .out_last(last_o[1]));

    encoder_n_serial #(.N(4), .LSB_FIRST(1'b0)) u_c (
        .clk(clk), .rst(rst_v[2]), .in_valid(in_valid_v[2]), .in_ready(in_ready_o[2]),
        .in_vec(vec_in[2][3:0]), .out_valid(out_valid_o[2]), .out_ready(out_ready_v[2]),
        .out_idx(idx_c), .out_none(none_o[2]), .out_last(last_o[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic void q_push(input int d, input logic [4:0] e);
        case (d)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic int q_size(input int d);
        case (d)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [4:0] q_pop(input int d);
        case (d)
            0: return q0.pop_front();
            1: return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    function automatic void q_clear(input int d);
        case (d)
            0: q0.delete();
            1: q1.delete();
            default: q2.delete();
        endcase
    endfunction

    // Reference: list the set bits in priority order; the final one is last; zero gives one "none" beat.
    function automatic void model(input int d, input logic [7:0] v);
        int n;
        int cnt;
        int seen;
        int i;
        n    = (d == 2) ? 4 : 8;
        cnt  = 0;
        seen = 0;
        for (int k = 0; k < n; k++) cnt += int'(v[k]);
        if (cnt == 0) begin
            q_push(d, {3'd0, 1'b1, 1'b1});
        end else begin
            for (int k = 0; k < n; k++) begin
                i = (d == 0) ? k : (n - 1 - k);
                if (v[i]) begin
                    seen++;
                    q_push(d, {3'(i), 1'b0, (seen == cnt)});
                end
            end
        end
    endfunction

    // Called at posedge+1: wait for in_ready, present the vector for one handshake.
    task automatic send(input int d, input logic [7:0] v_in);
        int t;
        logic [7:0] v;
        t = 0;
        v = (d == 2) ? (v_in & 8'h0F) : v_in;
        while (!in_ready_o[d] && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk($sformatf("in_ready_wait_dut%0d", d), int'(t < 100), 1);
        in_valid_v[d] = 1'b1;
        vec_in[d]     = v;
        model(d, v);
        @(posedge clk); #1;
        in_valid_v[d] = 1'b0;
        vec_in[d]     = 8'($urandom);
    endtask

    task automatic drain(input int d);
        int t;
        t = 0;
        while ((q_size(d) != 0 || !in_ready_o[d]) && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        chk($sformatf("drain_dut%0d", d), int'(t < 300), 1);
    endtask

    // Consumer ready pattern: 0 = always ready, 1 = random, 2 = toggling.
    initial begin
        out_ready_v = 3'b111;
        for (int d = 0; d < 3; d++) mode[d] = 0;
        forever begin
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) begin
                case (mode[d])
                    1: out_ready_v[d] = 1'($urandom_range(0, 1));
                    2: out_ready_v[d] = ~out_ready_v[d];
                    default: out_ready_v[d] = 1'b1;
                endcase
            end
        end
    end

    // Monitor: pops expected beats on each output handshake; checks stall stability and return to idle.
    initial begin
        logic [4:0] e;
        for (int d = 0; d < 3; d++) begin
            stall_prev[d] = 1'b0;
            idle_exp[d]   = 1'b0;
            stall_val[d]  = 5'd0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (rst_v[d]) begin
                    stall_prev[d] = 1'b0;
                    idle_exp[d]   = 1'b0;
                end else begin
                    if (idle_exp[d]) begin
                        chk($sformatf("idle_after_last_dut%0d", d),
                            int'({in_ready_o[d], out_valid_o[d]}), 2);
                        idle_exp[d] = 1'b0;
                    end
                    if (stall_prev[d]) begin
                        chk($sformatf("stall_hold_dut%0d", d),
                            int'({out_valid_o[d], idx_o[d], none_o[d], last_o[d]}),
                            int'({1'b1, stall_val[d]}));
                    end
                    if (out_valid_o[d] && out_ready_v[d]) begin
                        if (q_size(d) == 0) begin
                            n_vec++;
                            n_err++;
                            $display("FAIL unexpected_beat_dut%0d: got idx %0d with no beat expected",
                                     d, idx_o[d]);
                        end else begin
                            e = q_pop(d);
                            chk($sformatf("idx_dut%0d", d), int'(idx_o[d]), int'(e[4:2]));
                            chk($sformatf("none_dut%0d", d), int'(none_o[d]), int'(e[1]));
                            chk($sformatf("last_dut%0d", d), int'(last_o[d]), int'(e[0]));
                            chk($sformatf("in_ready_in_emit_dut%0d", d), int'(in_ready_o[d]), 0);
                            idle_exp[d] = last_o[d];
                        end
                    end
                    stall_prev[d] = out_valid_o[d] && !out_ready_v[d];
                    stall_val[d]  = {idx_o[d], none_o[d], last_o[d]};
                end
            end
        end
    end

    initial begin
        int r;
        rst_v      = 3'b111;
        in_valid_v = 3'b000;
        for (int d = 0; d < 3; d++) vec_in[d] = 8'h00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_in_ready_dut%0d", d), int'(in_ready_o[d]), 1);
            chk($sformatf("rst_out_valid_dut%0d", d), int'(out_valid_o[d]), 0);
            chk($sformatf("rst_outs_dut%0d", d), int'({idx_o[d], none_o[d], last_o[d]}), 0);
        end
        @(posedge clk); #1;
        rst_v = 3'b000;

        // Two-bit vector, both priority directions.
        send(0, 8'b1000_0001); drain(0);
        send(1, 8'b1000_0001); drain(1);

        // All-zero then single bit.
        send(0, 8'h00); drain(0);
        send(0, 8'h10); drain(0);

        // Full vector under a toggling consumer.
        mode[0] = 2;
        send(0, 8'hFF); drain(0);
        mode[0] = 0;
        @(posedge clk); #1;

        // Reset after the first beat: remaining beats must never appear.
        send(0, 8'b0110_0100);
        @(posedge clk); #1;
        rst_v[0] = 1'b1;
        q_clear(0);
        @(negedge clk);
        chk("midrst_out_valid", int'(out_valid_o[0]), 0);
        chk("midrst_in_ready", int'(in_ready_o[0]), 1);
        @(posedge clk); #1;
        rst_v[0] = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_no_beat", int'(out_valid_o[0]), 0);
            chk("post_rst_in_ready", int'(in_ready_o[0]), 1);
        end
        @(posedge clk); #1;

        // N=4 one-hot truth table.
        for (int b = 0; b < 4; b++) begin
            send(2, 8'(1 << b));
            drain(2);
        end

        // Random vectors under a random consumer.
        for (int d = 0; d < 3; d++) begin
            mode[d] = 1;
            repeat (25) begin
                r = int'($urandom_range(0, 3));
                case (r)
                    0: send(d, 8'h00);
                    1: send(d, 8'(1 << $urandom_range(0, 7)));
                    default: send(d, 8'($urandom));
                endcase
            end
            drain(d);
            mode[d] = 0;
        end

        repeat (3) @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("queue_empty_dut%0d", d), q_size(d), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
